// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the exhaustive truth-table sweeper.
// Pattern ordering and hold-counter sizing live here so the top and index generator agree.
package truth_table_sweeper_pkg;

   localparam int MAX_N_IN = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // HOLD is at least 2, so the counter always needs at least one bit.
   function automatic int hold_cnt_width(input int hold);
      return (hold < 2) ? 1 : $clog2(hold);
   endfunction

endpackage

// File: rtl/sweep_index_gen.sv
// Pattern index and hold counter for the sweeper; drives x registered, in binary or Gray order.
// sample_stb marks the last hold cycle of a pattern, last marks the final pattern.
module sweep_index_gen
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN = 5,
   parameter int HOLD = 20,
   parameter int GRAY = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            run,
   output logic [N_IN-1:0] x,
   output logic            sample_stb,
   output logic            last
);

   localparam int HCW = hold_cnt_width(HOLD);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);

   logic [N_IN-1:0] idx_q;
   logic [N_IN-1:0] idx_inc;
   logic [N_IN-1:0] x_q;
   logic [N_IN-1:0] x_inc;
   logic [HCW-1:0]  hold_q;

   // x is precomputed for the next index so the pattern leaves a flop, not a gray encoder.
   always_comb begin
      idx_inc = idx_q + N_IN'(1);
      x_inc   = (GRAY != 0) ? N_IN'(bin2gray(MAX_N_IN'(idx_inc))) : idx_inc;
   end

   assign sample_stb = (hold_q == HOLD_LAST);
   assign last       = &idx_q;
   assign x          = x_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         x_q    <= '0;
         hold_q <= '0;
      end else if (clear) begin
         idx_q  <= '0;
         x_q    <= '0;
         hold_q <= '0;
      end else if (run) begin
         if (sample_stb) begin
            if (!last) begin
               idx_q  <= idx_inc;
               x_q    <= x_inc;
               hold_q <= '0;
            end
         end else begin
            hold_q <= hold_q + HCW'(1);
         end
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus-and-check engine: walks every input pattern, compares y to EXPECTED,
// and reports mismatch count, first failing pattern and pass/done.
//
// state | meaning
// IDLE  | after reset, waiting for start
// APPLY | driving patterns, sampling y on the last hold cycle
// DONE  | sweep finished, results held until the next start
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int N_IN  = 5,
   parameter int N_OUT = 1,
   parameter int HOLD  = 20,
   parameter int GRAY  = 0,
   parameter logic [(1<<N_IN)*N_OUT-1:0] EXPECTED = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_OUT-1:0] y,
   output logic [N_IN-1:0]  x,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    err_count,
   output logic             first_err_valid,
   output logic [N_IN-1:0]  first_err_x
);

   localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};
   localparam logic [N_IN:0] ERR_ONE = (N_IN+1)'(1);

   state_t state_q, state_d;

   logic             clear;
   logic             run;
   logic             sample;
   logic             mismatch;
   logic             finish;
   logic             sample_stb;
   logic             last;
   logic [N_IN-1:0]  x_w;
   logic [N_OUT-1:0] exp_y;

   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [N_IN:0]    err_q;
   logic             fev_q;
   logic [N_IN-1:0]  fex_q;

   sweep_index_gen #(
      .N_IN (N_IN),
      .HOLD (HOLD),
      .GRAY (GRAY)
   ) u_index_gen (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .run        (run),
      .x          (x_w),
      .sample_stb (sample_stb),
      .last       (last)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = APPLY;
         APPLY:   if (finish) state_d = DONE;
         DONE:    if (start) state_d = APPLY;
         default: state_d = IDLE;
      endcase
   end

   // Expected value is looked up at the driven pattern, which differs from idx in Gray order.
   always_comb begin
      clear    = 1'b0;
      run      = 1'b0;
      case (state_q)
         IDLE:    clear = start;
         APPLY:   run   = 1'b1;
         DONE:    clear = start;
         default: ;
      endcase
      exp_y    = N_OUT'(EXPECTED >> (32'(x_w) * N_OUT));
      sample   = run && sample_stb;
      mismatch = sample && (y != exp_y);
      finish   = sample && last;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         err_q  <= '0;
         fev_q  <= 1'b0;
         fex_q  <= '0;
      end else begin
         busy_q <= (state_d == APPLY);
         done_q <= (state_d == DONE);
         if (clear) begin
            pass_q <= 1'b0;
            err_q  <= '0;
            fev_q  <= 1'b0;
            fex_q  <= '0;
         end else begin
            if (mismatch) begin
               if (err_q != ERR_MAX) err_q <= err_q + ERR_ONE;
               if (!fev_q) begin
                  fev_q <= 1'b1;
                  fex_q <= x_w;
               end
            end
            // Final-pattern mismatch is folded in here so pass agrees with err_count.
            if (finish) pass_q <= (err_q == '0) && !mismatch;
         end
      end
   end

   assign x               = x_w;
   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_err_valid = fev_q;
   assign first_err_x     = fex_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: four sweeper instances in different configurations, table-driven
// sweep results plus hand-written sequences for reset, restart and start-during-APPLY.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] start_v = '0;

   always #5 clk = ~clk;

   // u0: XOR gate against XOR table; u1: XOR with fault at x=7
   localparam logic [31:0] XOR5 = 32'h9669_6996;
   // u2: 3-bit Gray, 2-bit out, y = x[1:0]
   localparam logic [15:0] LOW2 = 16'hE4E4;

   logic [4:0] x0, x1, fex0, fex1;
   logic [2:0] x2, fex2;
   logic [3:0] x3, fex3;
   logic [5:0] err0, err1;
   logic [3:0] err2;
   logic [4:0] err3;
   logic [3:0] busy_w, done_w, pass_w, fev_w;
   logic       y0, y1, y3;
   logic [1:0] y2;

   assign y0 = ^x0;
   assign y1 = (x1 == 5'd7) ? 1'b0 : ^x1;
   assign y2 = x2[1:0];
   assign y3 = 1'b1;

   truth_table_sweeper #(.N_IN(5), .N_OUT(1), .HOLD(20), .GRAY(0), .EXPECTED(XOR5)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .y(y0), .x(x0), .busy(busy_w[0]),
      .done(done_w[0]), .pass(pass_w[0]), .err_count(err0), .first_err_valid(fev_w[0]),
      .first_err_x(fex0));

   truth_table_sweeper #(.N_IN(5), .N_OUT(1), .HOLD(20), .GRAY(0), .EXPECTED(XOR5)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .y(y1), .x(x1), .busy(busy_w[1]),
      .done(done_w[1]), .pass(pass_w[1]), .err_count(err1), .first_err_valid(fev_w[1]),
      .first_err_x(fex1));

   truth_table_sweeper #(.N_IN(3), .N_OUT(2), .HOLD(2), .GRAY(1), .EXPECTED(LOW2)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .y(y2), .x(x2), .busy(busy_w[2]),
      .done(done_w[2]), .pass(pass_w[2]), .err_count(err2), .first_err_valid(fev_w[2]),
      .first_err_x(fex2));

   truth_table_sweeper #(.N_IN(4), .N_OUT(1), .HOLD(20), .GRAY(0), .EXPECTED(16'h0000)) u3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .y(y3), .x(x3), .busy(busy_w[3]),
      .done(done_w[3]), .pass(pass_w[3]), .err_count(err3), .first_err_valid(fev_w[3]),
      .first_err_x(fex3));

   int obs_x[4], obs_err[4], obs_fex[4];
   always_comb begin
      obs_x[0] = int'(x0);   obs_x[1] = int'(x1);   obs_x[2] = int'(x2);   obs_x[3] = int'(x3);
      obs_err[0] = int'(err0); obs_err[1] = int'(err1);
      obs_err[2] = int'(err2); obs_err[3] = int'(err3);
      obs_fex[0] = int'(fex0); obs_fex[1] = int'(fex1);
      obs_fex[2] = int'(fex2); obs_fex[3] = int'(fex3);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      int inst;
      int pulse_cyc;
      int done_cyc;
      int err;
      int pass;
      int fev;
      int fex;
   } sweep_vec_t;

   sweep_vec_t vecs[4];
   int gray_tab[8];

   task automatic check_idle_zero(input int i, input string tag);
      check($sformatf("%s u%0d x", tag, i),         obs_x[i], 0);
      check($sformatf("%s u%0d busy", tag, i),      int'(busy_w[i]), 0);
      check($sformatf("%s u%0d done", tag, i),      int'(done_w[i]), 0);
      check($sformatf("%s u%0d pass", tag, i),      int'(pass_w[i]), 0);
      check($sformatf("%s u%0d err_count", tag, i), obs_err[i], 0);
      check($sformatf("%s u%0d first_err_valid", tag, i), int'(fev_w[i]), 0);
      check($sformatf("%s u%0d first_err_x", tag, i), obs_fex[i], 0);
   endtask

   // Pulses start in cycle 0 and returns the cycle in which done was first seen.
   task automatic run_sweep(input int inst, input int pulse_cyc, output int done_cyc);
      int cyc;
      @(negedge clk);
      start_v[inst] = 1'b1;
      @(negedge clk);
      start_v[inst] = 1'b0;
      cyc = 1;
      check($sformatf("u%0d busy at cycle 1", inst), int'(busy_w[inst]), 1);
      check($sformatf("u%0d x at cycle 1", inst), obs_x[inst], 0);
      while (!done_w[inst] && cyc < 2000) begin
         if (inst == 2 && cyc >= 2 && cyc <= 16 && (cyc % 2) == 0)
            check($sformatf("u2 gray x at cycle %0d", cyc), obs_x[2], gray_tab[cyc/2 - 1]);
         start_v[inst] = (cyc == pulse_cyc);
         @(negedge clk);
         cyc++;
      end
      start_v[inst] = 1'b0;
      done_cyc = cyc;
   endtask

   initial begin
      int dc;
      int cyc;

      gray_tab = '{0, 1, 3, 2, 6, 7, 5, 4};
      vecs[0] = '{inst: 0, pulse_cyc: 300, done_cyc: 641, err: 0,  pass: 1, fev: 0, fex: 0};
      vecs[1] = '{inst: 1, pulse_cyc: -1,  done_cyc: 641, err: 1,  pass: 0, fev: 1, fex: 7};
      vecs[2] = '{inst: 2, pulse_cyc: 5,   done_cyc: 17,  err: 0,  pass: 1, fev: 0, fex: 0};
      vecs[3] = '{inst: 3, pulse_cyc: -1,  done_cyc: 321, err: 16, pass: 0, fev: 1, fex: 0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) check_idle_zero(i, "reset");

      for (int v = 0; v < 4; v++) begin
         run_sweep(vecs[v].inst, vecs[v].pulse_cyc, dc);
         check($sformatf("vec%0d done cycle", v), dc, vecs[v].done_cyc);
         check($sformatf("vec%0d busy at done", v), int'(busy_w[vecs[v].inst]), 0);
         check($sformatf("vec%0d err_count", v), obs_err[vecs[v].inst], vecs[v].err);
         check($sformatf("vec%0d pass", v), int'(pass_w[vecs[v].inst]), vecs[v].pass);
         check($sformatf("vec%0d first_err_valid", v), int'(fev_w[vecs[v].inst]), vecs[v].fev);
         check($sformatf("vec%0d first_err_x", v), obs_fex[vecs[v].inst], vecs[v].fex);
      end

      // start held high through DONE: restart clears err_count in the next cycle
      @(negedge clk);
      start_v[3] = 1'b1;
      @(negedge clk);
      cyc = 1;
      while (!done_w[3] && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("held-start first done cycle", cyc, 321);
      check("held-start err at done", obs_err[3], 16);
      @(negedge clk);
      cyc++;
      check("restart done low", int'(done_w[3]), 0);
      check("restart busy high", int'(busy_w[3]), 1);
      check("restart err cleared", obs_err[3], 0);
      check("restart first_err_valid cleared", int'(fev_w[3]), 0);
      check("restart x", obs_x[3], 0);
      start_v[3] = 1'b0;
      while (!done_w[3] && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("restart second done cycle", cyc, 642);
      check("restart second err", obs_err[3], 16);

      // reset at cycle 100 of a sweep aborts and leaves no partial result
      @(negedge clk);
      start_v[3] = 1'b1;
      @(negedge clk);
      start_v[3] = 1'b0;
      cyc = 1;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("mid-sweep err before reset", obs_err[3], 4);
      check("mid-sweep x before reset", obs_x[3], 4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero(3, "mid-reset");
      run_sweep(3, -1, dc);
      check("post-reset done cycle", dc, vecs[3].done_cyc);
      check("post-reset err_count", obs_err[3], vecs[3].err);
      check("post-reset first_err_x", obs_fex[3], vecs[3].fex);
      check("post-reset pass", int'(pass_w[3]), vecs[3].pass);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
